// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter control-sequence generator.
// Pure declarations: no latency and no backpressure of its own.
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int TIMER_WIDTH   = 4;

    localparam logic [1:0] MODE_COUNT = 2'd0;
    localparam logic [1:0] MODE_LOAD  = 2'd1;
    localparam logic [1:0] MODE_FULL  = 2'd2;
    localparam logic [1:0] MODE_RST   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_COUNT,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_cycle_timer.sv
// Loadable down-counter with a zero flag that times the RST and COUNT phases.
// Load takes effect at the next edge; decrement saturates at zero, so no backpressure is needed.
module seq_cycle_timer
    import counter_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_val,
    input  logic                   dec,
    output logic                   zero
);

    logic [TIMER_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - TIMER_WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/counter_ctrl_seq.sv
// Commanded reset/count/load sequencer for the counter block, checking its output at the end.
// Outputs follow the state register by one edge; i_start is ignored while busy.
module counter_ctrl_seq
    import counter_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [3:0]       i_count_len,
    input  logic [WIDTH-1:0] i_load_a,
    input  logic [WIDTH-1:0] i_load_b,
    input  logic [WIDTH-1:0] i_counter1,
    output logic             o_ctr_reset_n,
    output logic             o_cnt_enable_n,
    output logic             o_ld_enable_n,
    output logic [WIDTH-1:0] o_load,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_match
);

    state_t                 state;
    state_t                 next_state;
    logic [1:0]             mode_q;
    logic [3:0]             len_q;
    logic [WIDTH-1:0]       load_a_q;
    logic [WIDTH-1:0]       load_b_q;
    logic [WIDTH-1:0]       expected;
    logic                   accept;
    logic                   tmr_load;
    logic                   tmr_dec;
    logic                   tmr_zero;
    logic [TIMER_WIDTH-1:0] tmr_val;

    assign accept = (state == ST_IDLE) && i_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_COUNT;
            len_q    <= '0;
            load_a_q <= '0;
            load_b_q <= '0;
            o_match  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                mode_q   <= i_mode;
                len_q    <= i_count_len;
                load_a_q <= i_load_a;
                load_b_q <= i_load_b;
                o_match  <= 1'b0;
            end
            if (state == ST_CHECK) begin
                o_match <= (i_counter1 == expected);
            end
        end
    end

    // Timer holds (remaining cycles - 1), so a phase exits on the cycle it reads zero.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = TIMER_WIDTH'(RST_CYCLES - 1);
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    tmr_load   = 1'b1;
                    next_state = (i_mode == MODE_LOAD) ? ST_LOAD_A : ST_RST;
                end
            end
            ST_RST: begin
                if (tmr_zero) begin
                    if (mode_q == MODE_RST) begin
                        next_state = ST_CHECK;
                    end else if (len_q != '0) begin
                        next_state = ST_COUNT;
                        tmr_load   = 1'b1;
                        tmr_val    = len_q - 4'd1;
                    end else if (mode_q == MODE_FULL) begin
                        next_state = ST_LOAD_A;
                    end else begin
                        next_state = ST_CHECK;
                    end
                end
            end
            ST_COUNT: begin
                if (tmr_zero) begin
                    next_state = (mode_q == MODE_FULL) ? ST_LOAD_A : ST_CHECK;
                end
            end
            ST_LOAD_A: next_state = ST_LOAD_B;
            ST_LOAD_B: next_state = ST_CHECK;
            ST_CHECK:  next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign tmr_dec = (state == ST_RST) || (state == ST_COUNT);

    seq_cycle_timer u_timer (
        .clk      (i_clk),
        .reset    (i_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        expected = '0;
        case (mode_q)
            MODE_LOAD,
            MODE_FULL:  expected = load_b_q;
            MODE_COUNT: expected = WIDTH'(len_q);
            default:    expected = '0;
        endcase
    end

    assign o_ctr_reset_n  = (state != ST_RST);
    assign o_cnt_enable_n = (state != ST_COUNT);
    assign o_ld_enable_n  = !((state == ST_LOAD_A) || (state == ST_LOAD_B));
    assign o_load         = (state == ST_LOAD_A) ? load_a_q :
                            (state == ST_LOAD_B) ? load_b_q : '0;
    assign o_busy         = (state != ST_IDLE);
    assign o_done         = (state == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl_seq.sv
// Bench for counter_ctrl_seq: per-cycle control traces built from the sequence rules,
// with a behavioural counter closing the feedback loop.
module tb_counter_ctrl_seq;

    localparam int W  = 4;
    localparam int RC = 2;

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_start = 1'b0;
    logic [1:0]   i_mode = '0;
    logic [3:0]   i_count_len = '0;
    logic [W-1:0] i_load_a = '0;
    logic [W-1:0] i_load_b = '0;
    logic [W-1:0] i_counter1;
    logic         o_ctr_reset_n, o_cnt_enable_n, o_ld_enable_n;
    logic [W-1:0] o_load;
    logic         o_busy, o_done, o_match;

    logic [W-1:0] ctr_q = '0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic         rst_n;
        logic         cnt_n;
        logic         ld_n;
        logic [W-1:0] load;
        logic         busy;
        logic         done;
    } obs_t;

    always #5 clk = ~clk;

    counter_ctrl_seq #(.RST_CYCLES(RC), .WIDTH(W)) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_count_len    (i_count_len),
        .i_load_a       (i_load_a),
        .i_load_b       (i_load_b),
        .i_counter1     (i_counter1),
        .o_ctr_reset_n  (o_ctr_reset_n),
        .o_cnt_enable_n (o_cnt_enable_n),
        .o_ld_enable_n  (o_ld_enable_n),
        .o_load         (o_load),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_match        (o_match)
    );

    // Behavioural model of the controlled counter: reset > load > count.
    always @(posedge clk) begin
        if (!o_ctr_reset_n)      ctr_q <= '0;
        else if (!o_ld_enable_n) ctr_q <= o_load;
        else if (!o_cnt_enable_n) ctr_q <= ctr_q + 1'b1;
    end
    assign i_counter1 = force_en ? force_val : ctr_q;

    function automatic obs_t observe();
        return {o_ctr_reset_n, o_cnt_enable_n, o_ld_enable_n, o_load, o_busy, o_done};
    endfunction

    function automatic obs_t idle_obs();
        return {1'b1, 1'b1, 1'b1, {W{1'b0}}, 1'b0, 1'b0};
    endfunction

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_seq(input logic [1:0] mode, input logic [3:0] len,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit scramble, output int busy_cycles);
        obs_t         exp_q[$];
        obs_t         e;
        obs_t         got;
        logic [W-1:0] exp_val;
        bit           exp_match;
        busy_cycles = 0;
        if (mode != 2'd1)
            for (int i = 0; i < RC; i++) exp_q.push_back({1'b0, 1'b1, 1'b1, {W{1'b0}}, 1'b1, 1'b0});
        if (mode == 2'd0 || mode == 2'd2)
            for (int i = 0; i < int'(len); i++) exp_q.push_back({1'b1, 1'b0, 1'b1, {W{1'b0}}, 1'b1, 1'b0});
        if (mode == 2'd1 || mode == 2'd2) begin
            exp_q.push_back({1'b1, 1'b1, 1'b0, a, 1'b1, 1'b0});
            exp_q.push_back({1'b1, 1'b1, 1'b0, b, 1'b1, 1'b0});
        end
        exp_q.push_back({1'b1, 1'b1, 1'b1, {W{1'b0}}, 1'b1, 1'b0});
        exp_q.push_back({1'b1, 1'b1, 1'b1, {W{1'b0}}, 1'b1, 1'b1});

        if (mode == 2'd1 || mode == 2'd2) exp_val = b;
        else if (mode == 2'd0)            exp_val = W'(len);
        else                              exp_val = '0;
        exp_match = force_en ? (force_val == exp_val) : 1'b1;

        i_start = 1'b1; i_mode = mode; i_count_len = len; i_load_a = a; i_load_b = b;
        @(posedge clk);
        #1;
        i_start = scramble ? 1'($urandom) : 1'b0;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            e = exp_q[c];
            got = observe();
            if (got.busy) busy_cycles++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL trace mode=%0d len=%0d cycle=%0d got=%h exp=%h", mode, len, c, got, e);
            end
            if (c == exp_q.size() - 1) begin
                checks++;
                if (o_match !== exp_match) begin
                    failures++;
                    $display("FAIL match_at_done mode=%0d got=%b exp=%b", mode, o_match, exp_match);
                end
                i_start = 1'b0;
            end else if (scramble) begin
                i_start = 1'($urandom);
                i_mode = 2'($urandom);
                i_count_len = 4'($urandom);
                i_load_a = W'($urandom);
                i_load_b = W'($urandom);
            end
        end
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== idle_obs() || o_match !== exp_match) begin
            failures++;
            $display("FAIL idle_after_done got=%h match=%b exp=%h match=%b", got, o_match, idle_obs(), exp_match);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b1; i_mode = 2'd2; i_count_len = 4'd7;
        repeat (3) @(negedge clk);
        checks++;
        if (observe() !== idle_obs() || o_match !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got=%h match=%b exp=%h match=0", observe(), o_match, idle_obs());
        end
        i_reset = 1'b0; i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b exp=0", o_busy);
        end
    endtask

    task automatic test_mode0_len15();
        int n;
        run_seq(2'd0, 4'd15, W'($urandom), W'($urandom), 1'b0, n);
        checks++;
        if (n != RC + 15 + 2) begin failures++; $display("FAIL mode0_busy got=%0d exp=%0d", n, RC + 17); end
    endtask

    task automatic test_mode1_load();
        int n;
        run_seq(2'd1, 4'd5, 4'b0011, 4'b1100, 1'b0, n);
        checks++;
        if (n != 4) begin failures++; $display("FAIL mode1_busy got=%0d exp=4", n); end
        force_en = 1'b1; force_val = 4'd3;
        run_seq(2'd1, 4'd5, 4'b0011, 4'b1100, 1'b0, n);
        force_en = 1'b0;
    endtask

    task automatic test_mode2_len0();
        int n;
        run_seq(2'd2, 4'd0, W'($urandom), W'($urandom), 1'b0, n);
        checks++;
        if (n != 6) begin failures++; $display("FAIL mode2_len0_busy got=%0d exp=6", n); end
    endtask

    task automatic test_mode3_from9();
        int n;
        run_seq(2'd1, 4'd0, 4'd2, 4'd9, 1'b0, n);
        run_seq(2'd3, 4'd11, 4'd1, 4'd9, 1'b0, n);
        checks++;
        if (n != RC + 2) begin failures++; $display("FAIL mode3_busy got=%0d exp=%0d", n, RC + 2); end
    endtask

    task automatic test_reset_mid_count();
        int n;
        i_start = 1'b1; i_mode = 2'd0; i_count_len = 4'd15;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (RC + 5) @(negedge clk);
        checks++;
        if (o_cnt_enable_n !== 1'b0) begin
            failures++;
            $display("FAIL count_before_reset cnt_n=%b exp=0", o_cnt_enable_n);
        end
        i_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (observe() !== idle_obs()) begin
            failures++;
            $display("FAIL reset_mid_seq got=%h exp=%h", observe(), idle_obs());
        end
        i_reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL no_done_after_reset cycle=%0d done=%b busy=%b exp=0/0", c, o_done, o_busy);
            end
        end
        run_seq(2'd0, 4'd4, '0, '0, 1'b0, n);
    endtask

    task automatic test_start_with_reset();
        i_reset = 1'b1; i_start = 1'b1; i_mode = 2'd3;
        @(negedge clk);
        i_reset = 1'b0; i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL start_with_reset busy=%b exp=0", o_busy); end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL start_dropped busy=%b exp=0", o_busy); end
    endtask

    task automatic test_busy_scramble();
        int n;
        run_seq(2'd2, 4'd6, 4'd10, 4'd5, 1'b1, n);
        run_seq(2'd0, 4'd9, 4'd1, 4'd2, 1'b1, n);
        run_seq(2'd1, 4'd3, 4'd14, 4'd7, 1'b1, n);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 30; it++) begin
            force_en = ($urandom_range(0, 3) == 0);
            force_val = W'($urandom);
            run_seq(2'($urandom), 4'($urandom), W'($urandom), W'($urandom), 1'($urandom), n);
        end
        force_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_mode0_len15();
        test_mode1_load();
        test_mode2_len0();
        test_mode3_from9();
        test_reset_mid_count();
        test_start_with_reset();
        test_busy_scramble();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_ctrl_seq.md
# counter_ctrl_seq

Synchronous control-sequence generator that drives the counter block's control interface: counter reset, active-low count enable, active-low load enable and the 4-bit load word. It replaces hand-written stimulus with a commanded sequence and checks the counter's 4-bit output against an expected value. It sits between a host/command source and the counter block; the counter's `i_*` control ports are driven from this block's `o_*` ports.

## Interface
Parameters:
- `RST_CYCLES`, 2: number of cycles `o_ctr_reset_n` is held low in RST (at least 1).
- `WIDTH`, 4: width of the load word and of the counter feedback.

Ports:
- `i_clk` in 1: single clock, rising edge.
- `i_reset` in 1: synchronous, active-high reset of this block.
- `i_start` in 1: command strobe, sampled only in IDLE.
- `i_mode` in 2: sequence select. 0 = reset+count, 1 = load, 2 = reset+count+load, 3 = reset only.
- `i_count_len` in 4: number of count-enable cycles (0–15).
- `i_load_a` in WIDTH: first load word.
- `i_load_b` in WIDTH: second load word.
- `i_counter1` in WIDTH: counter output fed back for checking.
- `o_ctr_reset_n` out 1: counter reset, active-low.
- `o_cnt_enable_n` out 1: counter count enable, active-low.
- `o_ld_enable_n` out 1: counter load enable, active-low.
- `o_load` out WIDTH: counter load word.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_done` out 1: one-cycle completion pulse.
- `o_match` out 1: check result. Valid with `o_done` and held until the next accepted start.

## Operation
- States: IDLE, RST, COUNT, LOAD_A, LOAD_B, CHECK, DONE.
- Accepting a command: in IDLE, `i_start=1` latches `i_mode`, `i_count_len`, `i_load_a` and `i_load_b`. Later changes to these inputs are ignored until the next IDLE. `i_start` is ignored while busy.
- State sequence by mode:
  - Mode 0: RST → COUNT → CHECK.
  - Mode 1: LOAD_A → LOAD_B → CHECK.
  - Mode 2: RST → COUNT → LOAD_A → LOAD_B → CHECK.
  - Mode 3: RST → CHECK.
  - Every sequence ends CHECK → DONE → IDLE.
- RST: `o_ctr_reset_n=0` for exactly RST_CYCLES cycles.
- COUNT: `o_cnt_enable_n=0` for exactly the latched `i_count_len` cycles. If the length is 0, COUNT is skipped (0 cycles).
- LOAD_A and LOAD_B: one cycle each, `o_ld_enable_n=0`, `o_load` = the latched a or b word.
- Outside these states: `o_cnt_enable_n=1`, `o_ld_enable_n=1`, `o_ctr_reset_n=1`, `o_load=0`. At most one of reset, count enable or load enable is active in any cycle.
- Expected value for the check:
  - Modes 0 and 3: `count_len mod 2^WIDTH` (0 for mode 3).
  - Modes 1 and 2: the latched `i_load_b`.
- CHECK: one cycle. Drives no enables, which gives the registered counter one cycle to settle. `i_counter1` is compared at the end of CHECK, and the result is registered into `o_match`.
- DONE: `o_done=1` for one cycle, then IDLE.
- Internal cycle counter: 4 bits, shared by RST and COUNT, reloaded on each state entry. No wrap occurs because the maximum length is 15.

## Timing
- Reset values: state IDLE, `o_ctr_reset_n=1`, `o_cnt_enable_n=1`, `o_ld_enable_n=1`, `o_load=0`, `o_busy=0`, `o_done=0`, `o_match=0`.
- Reset mid-sequence: takes effect at the next edge. All counter controls are deasserted immediately and `o_done` is not pulsed.
- Start latency: if `i_start` is sampled at edge k, the first sequence output is active in the cycle after edge k. `o_busy` rises at edge k.
- Total busy cycles:
  - Mode 0: RST_CYCLES + len + 2.
  - Mode 1: 4.
  - Mode 2: RST_CYCLES + len + 4.
  - Mode 3: RST_CYCLES + 2.
- Back-to-back: the earliest next start is sampled in the IDLE cycle after DONE.
- `i_start` together with `i_reset`: reset wins and the start is dropped.

## Structure
- Shared package `counter_ctrl_pkg`:
  - state enum;
  - mode constants `MODE_COUNT`, `MODE_LOAD`, `MODE_FULL`, `MODE_RST`;
  - default `WIDTH`.
- One sub-module, `seq_cycle_timer`: a loadable 4-bit down-counter with a zero flag, used for the RST and COUNT durations.
- The FSM, latches and checker stay in the top module.

## Test plan
- Mode 0, len=15, counter model attached: `o_cnt_enable_n` is low for exactly 15 cycles, `i_counter1=15` in CHECK, `o_done` pulses with `o_match=1`.
- Mode 1, a=4'b0011, b=4'b1100: `o_load` is 3 then 12 on consecutive cycles with `o_ld_enable_n=0`, and `o_match=1`. Forcing `i_counter1=3` instead gives `o_match=0`.
- Mode 2, len=0, RST_CYCLES=2: the sequence is RST(2) → LOAD_A → LOAD_B → CHECK → DONE, 6 busy cycles, and COUNT never asserts.
- Mode 3 with a counter at 9: `o_ctr_reset_n` is low for 2 cycles, `i_counter1=0` at CHECK, `o_match=1`, 4 busy cycles.
- `i_reset` pulsed during COUNT cycle 5 of 15: all controls return to 1 the next cycle, `o_busy=0`, no `o_done`. A new start is accepted afterwards.
- `i_start` pulsed while busy, and operand inputs changed mid-run: there is no effect on the sequence and the latched values are used throughout.
